// File: rtl/lossy_link_pipe.sv
// Multi-lane fixed-latency lossy link: beats accepted under valid/ready re-emerge DELAY cycles later.
// Errors are externally requested per beat and applied as flag, drop or corrupt; optional consecutive-error bound.
module lossy_link_pipe #(
   parameter int                CHANNELS       = 1,
   parameter int                DATA_W         = 8,
   parameter int                DELAY          = 2,
   parameter int                ERR_MODE       = 0,
   parameter logic [DATA_W-1:0] ERR_MASK       = '1,
   parameter int                MAX_CONSEC_ERR = 0,
   parameter int                STAT_W         = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [CHANNELS-1:0]        i_in_valid,
   output logic [CHANNELS-1:0]        o_in_ready,
   input  logic [CHANNELS*DATA_W-1:0] i_in_payload,
   input  logic [CHANNELS-1:0]        i_stall,
   input  logic [CHANNELS-1:0]        i_err_inject,
   output logic [CHANNELS-1:0]        o_in_error,
   output logic [CHANNELS-1:0]        o_out_valid,
   output logic [CHANNELS*DATA_W-1:0] o_out_payload,
   output logic [CHANNELS-1:0]        o_out_error,
   output logic [CHANNELS*STAT_W-1:0] o_stat_sent,
   output logic [CHANNELS*STAT_W-1:0] o_stat_err
);

   localparam int                CW      = (MAX_CONSEC_ERR > 0) ? $clog2(MAX_CONSEC_ERR + 1) : 1;
   localparam logic [DATA_W-1:0] LP_MASK = (ERR_MODE == 2) ? ERR_MASK : '0;
   localparam logic              LP_DROP = (ERR_MODE == 1);
   localparam logic              LP_FLAG = (ERR_MODE != 1);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      logic              w_accept;
      logic              w_force_clean;
      logic              w_in_error;
      logic              w_s0_vld;
      logic [DATA_W-1:0] w_s0_dat;
      logic              w_s0_err;
      logic [CW-1:0]     r_consec;
      logic [DELAY-1:0]  r_vld;
      logic [DELAY-1:0]  r_err;
      logic [DATA_W-1:0] r_dat [DELAY];
      logic [STAT_W-1:0] r_sent;
      logic [STAT_W-1:0] r_err_cnt;

      assign o_in_ready[g]  = i_rst_n & ~i_stall[g];
      assign w_accept       = i_in_valid[g] & o_in_ready[g];
      assign w_force_clean  = (MAX_CONSEC_ERR > 0) && (r_consec == CW'(MAX_CONSEC_ERR));
      assign w_in_error     = w_accept & i_err_inject[g] & ~w_force_clean;
      assign o_in_error[g]  = w_in_error;

      // Stage 0 is zeroed when empty so the output payload is 0 whenever out_valid is low.
      assign w_s0_vld = w_accept & ~(LP_DROP & w_in_error);
      assign w_s0_dat = w_s0_vld ? (i_in_payload[g*DATA_W +: DATA_W] ^ (w_in_error ? LP_MASK : '0)) : '0;
      assign w_s0_err = w_s0_vld & w_in_error & LP_FLAG;

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            r_vld <= '0;
            r_err <= '0;
            for (int k = 0; k < DELAY; k++) r_dat[k] <= '0;
         end else begin
            r_vld[0] <= w_s0_vld;
            r_err[0] <= w_s0_err;
            r_dat[0] <= w_s0_dat;
            for (int k = 1; k < DELAY; k++) begin
               r_vld[k] <= r_vld[k-1];
               r_err[k] <= r_err[k-1];
               r_dat[k] <= r_dat[k-1];
            end
         end
      end

      always_ff @(posedge i_clk) begin
         if (!i_rst_n || MAX_CONSEC_ERR == 0) begin
            r_consec <= '0;
         end else if (w_accept) begin
            r_consec <= w_in_error ? r_consec + CW'(1) : '0;
         end
      end

      // Counters stick at all-ones rather than wrapping.
      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            r_sent    <= '0;
            r_err_cnt <= '0;
         end else begin
            if (w_accept && r_sent != '1)      r_sent    <= r_sent + STAT_W'(1);
            if (w_in_error && r_err_cnt != '1) r_err_cnt <= r_err_cnt + STAT_W'(1);
         end
      end

      assign o_out_valid[g]                     = r_vld[DELAY-1];
      assign o_out_error[g]                     = r_err[DELAY-1];
      assign o_out_payload[g*DATA_W +: DATA_W]  = r_dat[DELAY-1];
      assign o_stat_sent[g*STAT_W +: STAT_W]    = r_sent;
      assign o_stat_err[g*STAT_W +: STAT_W]     = r_err_cnt;
   end

endmodule

// File: tb/tb_lossy_link_pipe.sv
// Drives three differently-configured links with shared stimulus and checks each against a delivery-schedule model.
module tb_lossy_link_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  in_valid, stall, err_inj;
   logic [15:0] in_payload;

   logic [1:0]  a_rdy, a_ierr, a_ov, a_oerr, b_rdy, b_ierr, b_ov, b_oerr, c_rdy, c_ierr, c_ov, c_oerr;
   logic [15:0] a_op, b_op, c_op;
   logic [31:0] a_ss, a_se, b_ss, b_se;
   logic [7:0]  c_ss, c_se;

   always #5 clk = ~clk;

   lossy_link_pipe #(.CHANNELS(2), .DATA_W(8), .DELAY(2), .ERR_MODE(0), .ERR_MASK(8'hFF),
                     .MAX_CONSEC_ERR(0), .STAT_W(16)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(a_rdy),
      .i_in_payload(in_payload), .i_stall(stall), .i_err_inject(err_inj), .o_in_error(a_ierr),
      .o_out_valid(a_ov), .o_out_payload(a_op), .o_out_error(a_oerr),
      .o_stat_sent(a_ss), .o_stat_err(a_se));

   lossy_link_pipe #(.CHANNELS(2), .DATA_W(8), .DELAY(3), .ERR_MODE(1), .ERR_MASK(8'hFF),
                     .MAX_CONSEC_ERR(0), .STAT_W(16)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(b_rdy),
      .i_in_payload(in_payload), .i_stall(stall), .i_err_inject(err_inj), .o_in_error(b_ierr),
      .o_out_valid(b_ov), .o_out_payload(b_op), .o_out_error(b_oerr),
      .o_stat_sent(b_ss), .o_stat_err(b_se));

   lossy_link_pipe #(.CHANNELS(2), .DATA_W(8), .DELAY(2), .ERR_MODE(2), .ERR_MASK(8'hFF),
                     .MAX_CONSEC_ERR(3), .STAT_W(4)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(c_rdy),
      .i_in_payload(in_payload), .i_stall(stall), .i_err_inject(err_inj), .o_in_error(c_ierr),
      .o_out_valid(c_ov), .o_out_payload(c_op), .o_out_error(c_oerr),
      .o_stat_sent(c_ss), .o_stat_err(c_se));

   logic [1:0]  o_rdy [3], o_ierr [3], o_ov [3], o_oerr [3];
   logic [15:0] o_op [3];
   logic [15:0] o_ss [3][2], o_se [3][2];

   assign o_rdy  = '{a_rdy, b_rdy, c_rdy};
   assign o_ierr = '{a_ierr, b_ierr, c_ierr};
   assign o_ov   = '{a_ov, b_ov, c_ov};
   assign o_oerr = '{a_oerr, b_oerr, c_oerr};
   assign o_op   = '{a_op, b_op, c_op};

   always_comb begin
      for (int l = 0; l < 2; l++) begin
         o_ss[0][l] = a_ss[l*16 +: 16];
         o_se[0][l] = a_se[l*16 +: 16];
         o_ss[1][l] = b_ss[l*16 +: 16];
         o_se[1][l] = b_se[l*16 +: 16];
         o_ss[2][l] = {12'd0, c_ss[l*4 +: 4]};
         o_se[2][l] = {12'd0, c_se[l*4 +: 4]};
      end
   end

   // Per-instance configuration seen by the model.
   int MODE [3] = '{0, 1, 2};
   int DLY  [3] = '{2, 3, 2};
   int MCE  [3] = '{0, 0, 3};
   int SMAX [3] = '{65535, 65535, 15};

   int         tests = 0;
   int         fails = 0;
   int         edge_n = 0;
   int         consec [3][2];
   int         ss [3][2];
   int         se [3][2];
   logic       ev [3][2][8];
   logic       ee [3][2][8];
   logic [7:0] ep [3][2][8];
   logic [1:0] cap_ierr_c;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: apply inputs, check combinational outputs, advance the model, check registered outputs.
   task automatic cyc(input logic rst, input logic [1:0] v, input logic [15:0] p,
                      input logic [1:0] s, input logic [1:0] e);
      logic rdy, acc, fc, ie;
      int   slot;
      rst_n = rst; in_valid = v; in_payload = p; stall = s; err_inj = e;
      #2;
      cap_ierr_c = c_ierr;
      for (int i = 0; i < 3; i++) begin
         for (int l = 0; l < 2; l++) begin
            rdy = rst & ~s[l];
            acc = v[l] & rdy;
            fc  = (MCE[i] > 0) && (consec[i][l] == MCE[i]);
            ie  = acc & e[l] & ~fc;
            chk($sformatf("in_ready i%0d l%0d", i, l), 32'(o_rdy[i][l]), 32'(rdy));
            chk($sformatf("in_error i%0d l%0d", i, l), 32'(o_ierr[i][l]), 32'(ie));
            if (!rst) begin
               consec[i][l] = 0; ss[i][l] = 0; se[i][l] = 0;
               for (int k = 0; k < 8; k++) begin
                  ev[i][l][k] = 1'b0; ee[i][l][k] = 1'b0; ep[i][l][k] = 8'h00;
               end
            end else if (acc) begin
               if (ss[i][l] < SMAX[i]) ss[i][l]++;
               if (ie && se[i][l] < SMAX[i]) se[i][l]++;
               consec[i][l] = ie ? consec[i][l] + 1 : 0;
               if (!(MODE[i] == 1 && ie)) begin
                  slot = (edge_n + DLY[i]) % 8;
                  ev[i][l][slot] = 1'b1;
                  ee[i][l][slot] = ie && (MODE[i] != 1);
                  ep[i][l][slot] = p[l*8 +: 8] ^ ((MODE[i] == 2 && ie) ? 8'hFF : 8'h00);
               end
            end
         end
      end
      @(posedge clk);
      #1;
      edge_n++;
      slot = edge_n % 8;
      for (int i = 0; i < 3; i++) begin
         for (int l = 0; l < 2; l++) begin
            chk($sformatf("out_valid i%0d l%0d", i, l), 32'(o_ov[i][l]), 32'(ev[i][l][slot]));
            chk($sformatf("out_payload i%0d l%0d", i, l), 32'(o_op[i][l*8 +: 8]),
                ev[i][l][slot] ? 32'(ep[i][l][slot]) : 32'd0);
            chk($sformatf("out_error i%0d l%0d", i, l), 32'(o_oerr[i][l]), 32'(ee[i][l][slot]));
            chk($sformatf("stat_sent i%0d l%0d", i, l), 32'(o_ss[i][l]), 32'(ss[i][l]));
            chk($sformatf("stat_err i%0d l%0d", i, l), 32'(o_se[i][l]), 32'(se[i][l]));
            ev[i][l][slot] = 1'b0; ee[i][l][slot] = 1'b0; ep[i][l][slot] = 8'h00;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b1, 2'b00, 16'h0000, 2'b00, 2'b00);
   endtask

   initial begin
      logic [4:0] seq;
      int         nseq;

      // Reset held with valid high, then a single beat.
      for (int k = 0; k < 3; k++) cyc(1'b0, 2'b11, 16'h1111, 2'b00, 2'b00);
      cyc(1'b1, 2'b01, 16'h0011, 2'b00, 2'b00);
      idle(3);
      chk("t1 a sent", 32'(o_ss[0][0]), 32'd1);

      // Back-to-back clean beats on lane 0.
      cyc(1'b0, 2'b00, 16'h0000, 2'b00, 2'b00);
      for (int k = 1; k <= 10; k++) cyc(1'b1, 2'b01, 16'(k), 2'b00, 2'b00);
      idle(3);
      chk("t2 a sent", 32'(o_ss[0][0]), 32'd10);
      chk("t2 a err", 32'(o_se[0][0]), 32'd0);

      // Middle beat errored: dropped on the drop link.
      cyc(1'b0, 2'b00, 16'h0000, 2'b00, 2'b00);
      cyc(1'b1, 2'b01, 16'h0032, 2'b00, 2'b00);
      cyc(1'b1, 2'b01, 16'h0033, 2'b00, 2'b01);
      cyc(1'b1, 2'b01, 16'h0034, 2'b00, 2'b00);
      idle(4);
      chk("t3 b sent", 32'(o_ss[1][0]), 32'd3);
      chk("t3 b err", 32'(o_se[1][0]), 32'd1);

      // Corrupt on lane 1 while lane 0 is clean.
      cyc(1'b0, 2'b00, 16'h0000, 2'b00, 2'b00);
      cyc(1'b1, 2'b11, 16'h5A5A, 2'b00, 2'b10);
      cyc(1'b1, 2'b00, 16'h0000, 2'b00, 2'b00);
      chk("t4 c lane1 payload", 32'(c_op[15:8]), 32'h0A5);
      chk("t4 c lane0 payload", 32'(c_op[7:0]), 32'h05A);
      chk("t4 c out_error", 32'(c_oerr), 32'h2);
      idle(2);

      // Consecutive-error bound with a stall inside the run.
      cyc(1'b0, 2'b00, 16'h0000, 2'b00, 2'b00);
      seq = '0; nseq = 0;
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, 2'b01, 16'(8'h40 + k), (k == 1) ? 2'b01 : 2'b00, 2'b01);
         if (k != 1) begin
            seq = {seq[3:0], cap_ierr_c[0]};
            nseq++;
         end
      end
      idle(3);
      chk("t5 accepted", 32'(nseq), 32'd5);
      chk("t5 in_error seq", 32'(seq), 32'b11101);

      // Saturation, then reset with beats in flight.
      cyc(1'b0, 2'b00, 16'h0000, 2'b00, 2'b00);
      for (int k = 0; k < 40; k++) cyc(1'b1, 2'b11, 16'(k * 3), 2'b00, 2'b11);
      chk("t6 c sent sat", 32'(o_ss[2][0]), 32'hF);
      chk("t6 c err sat", 32'(o_se[2][1]), 32'hF);
      cyc(1'b1, 2'b11, 16'hBEEF, 2'b00, 2'b00);
      cyc(1'b0, 2'b11, 16'hCAFE, 2'b00, 2'b00);
      idle(4);
      chk("t6 a quiet", 32'(a_ov), 32'd0);

      // Randomized traffic against the model.
      for (int k = 0; k < 500; k++) begin
         cyc(($urandom_range(0, 59) != 0), 2'($urandom), 16'($urandom),
             {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
             {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)});
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
